// File: rtl/noc_credit_tx.sv
// Credit-based NoC link transmitter: 2-entry flit buffer in front of a credit-gated send strobe.
// Optional NOC_CREDIT_TX_STATS_EN adds flit/packet/stall statistics counters.
module noc_credit_tx #(
   parameter int unsigned  FLIT_WIDTH        = 32,
   parameter int unsigned  DEST_WIDTH        = 6,
   parameter int unsigned  FLIT_BUFFER_DEPTH = 4,
   localparam int unsigned CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
   input  logic                    clk_noc,
   input  logic                    rst_noc_sync,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [FLIT_WIDTH-1:0]   in_data,
   input  logic [DEST_WIDTH-1:0]   in_dest,
   input  logic                    in_is_tail,
   output logic [FLIT_WIDTH-1:0]   data_out,
   output logic [DEST_WIDTH-1:0]   dest_out,
   output logic                    is_tail_out,
   output logic                    send_out,
   input  logic                    credit_in,
   output logic [CREDIT_WIDTH-1:0] credits,
   output logic                    idle,
   output logic                    err_credit_ovf
`ifdef NOC_CREDIT_TX_STATS_EN
   ,
   output logic [31:0]             stat_flits,
   output logic [31:0]             stat_pkts,
   output logic [31:0]             stat_stall
`endif
);

   localparam logic [CREDIT_WIDTH-1:0] CREDITS_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

   typedef struct packed {
      logic [FLIT_WIDTH-1:0] data;
      logic [DEST_WIDTH-1:0] dest;
      logic                  tail;
   } flit_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   flit_t                   ent0_q, ent0_d;
   flit_t                   ent1_q, ent1_d;
   flit_t                   out_q, out_d;
   logic                    send_q, send_d;
   logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
   logic                    err_q, err_d;
   logic                    in_ready_q, in_ready_d;
   logic                    idle_q, idle_d;

   flit_t in_flit;
   logic  push;
   logic  fire;

   assign in_flit = '{data: in_data, dest: in_dest, tail: in_is_tail};
   assign push    = in_valid & in_ready_q;
   // Credits arriving this cycle only count from the next cycle, keeping fire off credit_in.
   assign fire    = (state_q != EMPTY) && (credits_q != '0);

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         state_q    <= EMPTY;
         ent0_q     <= '0;
         ent1_q     <= '0;
         out_q      <= '0;
         send_q     <= 1'b0;
         credits_q  <= CREDITS_MAX;
         err_q      <= 1'b0;
         in_ready_q <= 1'b1;
         idle_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         ent0_q     <= ent0_d;
         ent1_q     <= ent1_d;
         out_q      <= out_d;
         send_q     <= send_d;
         credits_q  <= credits_d;
         err_q      <= err_d;
         in_ready_q <= in_ready_d;
         idle_q     <= idle_d;
      end
   end

   // Buffer FSM: ent0 is always the head; a pop shifts ent1 down.
   always_comb begin
      state_d = state_q;
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      unique case (state_q)
         EMPTY: begin
            if (push) begin
               ent0_d  = in_flit;
               state_d = ONE;
            end
         end
         ONE: begin
            if (push && fire) begin
               ent0_d = in_flit;
            end else if (push) begin
               ent1_d  = in_flit;
               state_d = FULL;
            end else if (fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (fire) begin
               ent0_d  = ent1_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Output register, credit counter and derived status flags.
   always_comb begin
      send_d    = fire;
      out_d     = out_q;
      credits_d = credits_q;
      err_d     = err_q;
      if (fire) begin
         out_d = ent0_q;
      end
      unique case ({fire, credit_in})
         2'b10: credits_d = credits_q - CREDIT_WIDTH'(1);
         2'b01: begin
            if (credits_q == CREDITS_MAX) begin
               err_d = 1'b1;
            end else begin
               credits_d = credits_q + CREDIT_WIDTH'(1);
            end
         end
         default: credits_d = credits_q;
      endcase
      in_ready_d = (state_d != FULL);
      idle_d     = (state_d == EMPTY) && (credits_d == CREDITS_MAX);
   end

   assign data_out       = out_q.data;
   assign dest_out       = out_q.dest;
   assign is_tail_out    = out_q.tail;
   assign send_out       = send_q;
   assign credits        = credits_q;
   assign err_credit_ovf = err_q;
   assign in_ready       = in_ready_q;
   assign idle           = idle_q;

`ifdef NOC_CREDIT_TX_STATS_EN
   logic [31:0] stat_flits_q, stat_flits_d;
   logic [31:0] stat_pkts_q, stat_pkts_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   always_comb begin
      stat_flits_d = stat_flits_q + 32'(fire);
      stat_pkts_d  = stat_pkts_q + 32'(fire & ent0_q.tail);
      stat_stall_d = stat_stall_q + 32'((state_q != EMPTY) && (credits_q == '0));
   end

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         stat_flits_q <= '0;
         stat_pkts_q  <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_flits_q <= stat_flits_d;
         stat_pkts_q  <= stat_pkts_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_flits = stat_flits_q;
   assign stat_pkts  = stat_pkts_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule
